// File: rtl/pdp8_pkg.sv
// Shared PDP-8 bench types: stimulus word sources, responder FSM states
// and the 12-bit LFSR feedback taps.
package pdp8_pkg;

    localparam int PDP8_DATA_WIDTH = 12;
    localparam int PDP8_ADDR_WIDTH = 12;

    // Feedback taps at bits 11, 5, 3 and 0.
    localparam logic [11:0] LFSR12_TAPS       = 12'o4051;
    localparam logic [11:0] DEFAULT_STIM_WORD = 12'o7000;

    typedef enum logic [1:0] {
        STIM_CONST = 2'd0,
        STIM_INCR  = 2'd1,
        STIM_LFSR  = 2'd2,
        STIM_ECHO  = 2'd3
    } stim_mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } fsm_state_e;

endpackage

// File: rtl/stim_word_gen.sv
// Instruction word source for the fetch responder: holds the latched mode and
// the current word, and steps it only when a response is actually issued.
module stim_word_gen
    import pdp8_pkg::*;
#(
    parameter int DATA_WIDTH = PDP8_DATA_WIDTH,
    parameter int ADDR_WIDTH = PDP8_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  stim_mode_e            mode_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [ADDR_WIDTH-1:0] echo_addr_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    stim_mode_e            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  feedback;

    always_comb begin
        mode_d   = mode_q;
        word_d   = word_q;
        feedback = ^(word_q & DATA_WIDTH'(LFSR12_TAPS));
        if (load_i) begin
            mode_d = mode_i;
            // An all-zero LFSR would lock up, so a zero seed becomes 1.
            if (mode_i == STIM_LFSR && seed_i == '0) begin
                word_d = DATA_WIDTH'(1);
            end else begin
                word_d = seed_i;
            end
        end else if (advance_i) begin
            case (mode_q)
                STIM_INCR: word_d = word_q + DATA_WIDTH'(1);
                STIM_LFSR: word_d = {word_q[DATA_WIDTH-2:0], feedback};
                default:   word_d = word_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= STIM_CONST;
            word_q <= '0;
        end else begin
            mode_q <= mode_d;
            word_q <= word_d;
        end
    end

    assign word_o = (mode_q == STIM_ECHO) ? DATA_WIDTH'(echo_addr_i) : word_q;

endmodule

// File: rtl/fetch_stim_responder.sv
// Clocked IFU read responder: answers each request edge with an instruction
// word after a fixed latency, counting responses and flagging overruns.
module fetch_stim_responder
    import pdp8_pkg::*;
#(
    parameter int DATA_WIDTH                = PDP8_DATA_WIDTH,
    parameter int ADDR_WIDTH                = PDP8_ADDR_WIDTH,
    parameter int CYCLE_TO_LATCH_FIRST_DATA = 2,
    parameter int CNT_WIDTH                 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [CNT_WIDTH-1:0]  num_stimuli,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  stim_count
);

    localparam logic [3:0] LAT_LOAD = 4'(CYCLE_TO_LATCH_FIRST_DATA - 1);
    localparam fsm_state_e AFTER_ARMED = (CYCLE_TO_LATCH_FIRST_DATA == 1) ? RESP : WAIT;

    fsm_state_e            state_q, state_d;
    logic                  req_q;
    logic                  req_edge;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [3:0]            lat_q, lat_d;
    logic                  overrun_q, overrun_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  gen_load, gen_advance;
    logic [DATA_WIDTH-1:0] gen_word;

    assign req_edge = ifu_rd_req && !req_q;

    stim_word_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_word_gen (
        .clk         (clk),
        .reset       (reset),
        .load_i      (gen_load),
        .advance_i   (gen_advance),
        .mode_i      (stim_mode_e'(mode)),
        .seed_i      (seed),
        .echo_addr_i (addr_d),
        .word_o      (gen_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start wins over everything so a restart drops any pending response.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        overrun_d   = overrun_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        gen_load    = 1'b0;
        gen_advance = 1'b0;
        if (start) begin
            state_d   = ARMED;
            num_d     = num_stimuli;
            cnt_d     = '0;
            lat_d     = '0;
            overrun_d = 1'b0;
            gen_load  = 1'b1;
        end else begin
            case (state_q)
                ARMED: begin
                    if (num_q == '0) begin
                        state_d = DONE;
                    end else if (req_edge) begin
                        addr_d  = ifu_rd_addr;
                        lat_d   = LAT_LOAD;
                        state_d = AFTER_ARMED;
                    end
                end
                WAIT: begin
                    lat_d = lat_q - 4'd1;
                    if (lat_d == 4'd0) begin
                        state_d = RESP;
                    end
                    if (req_edge) begin
                        overrun_d = 1'b1;
                    end
                end
                RESP: begin
                    state_d = (cnt_q >= num_q) ? DONE : ARMED;
                    if (req_edge) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
            if (state_d == RESP && state_q != RESP) begin
                valid_d     = 1'b1;
                data_d      = gen_word;
                gen_advance = 1'b1;
                if (cnt_q != num_q) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= 1'b0;
            addr_q    <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            req_q     <= ifu_rd_req;
            addr_q    <= addr_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        busy = (state_q == ARMED) || (state_q == WAIT) || (state_q == RESP);
        done = (state_q == DONE);
    end

    assign ifu_rd_valid = valid_q;
    assign ifu_rd_data  = data_q;
    assign overrun      = overrun_q;
    assign stim_count   = cnt_q;

endmodule
